mem_stage_ctrl: RTL and testbench

Memory-stage controller for the pipelined RiSC-16 core, between execute and the synchronous data RAM (`mem_data`). It accepts load/store requests with a valid/ready handshake, drives the RAM's write-enable/address/data, absorbs the RAM's one-cycle read latency, and returns load results with a valid/ready handshake. It also decodes a small memory-mapped I/O window: an LED register and a free-running cycle counter. Out-of-range accesses raise a sticky fault flag.

---
 rtl/mem_stage_ctrl_pkg.sv | 14 +
 rtl/mem_stage_ctrl_mmio.sv | 48 ++++
 rtl/mem_stage_ctrl.sv | 111 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and MMIO address map for the RiSC-16 memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RSP_HOLD  = 2'd2
  } state_t;

  localparam logic [15:0] MMIO_BASE   = 16'hFF00;
  localparam logic [15:0] ADDR_LED    = 16'hFF00;
  localparam logic [15:0] ADDR_CYCLES = 16'hFF01;

endpackage

// File: rtl/mem_stage_ctrl_mmio.sv
// Memory-mapped I/O block: LED register, free-running cycle counter, read mux.
module mem_mmio
  import mem_stage_pkg::*;
#(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [p_ADDR_LEN-1:0] i_addr,
  input  logic [p_WORD_LEN-1:0] i_wdata,
  output logic [p_WORD_LEN-1:0] o_rd_data,
  output logic [p_WORD_LEN-1:0] o_led
);

  logic [p_WORD_LEN-1:0] r_led;
  logic [p_WORD_LEN-1:0] r_cycles;
  logic                  w_sel_led;
  logic                  w_sel_cycles;

  assign w_sel_led    = (i_addr == p_ADDR_LEN'(ADDR_LED));
  assign w_sel_cycles = (i_addr == p_ADDR_LEN'(ADDR_CYCLES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_led    <= '0;
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 1'b1;
      if (i_wr_en && w_sel_led) begin
        r_led <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (w_sel_led) begin
      o_rd_data = r_led;
    end else if (w_sel_cycles) begin
      o_rd_data = r_cycles;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/mem_stage_ctrl.sv
// RiSC-16 memory-stage controller: request/response handshakes, RAM access,
// MMIO decode and sticky out-of-range fault.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int p_WORD_LEN     = 16,
  parameter int p_ADDR_LEN     = 16,
  parameter int p_MEM_ADDR_LEN = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [p_ADDR_LEN-1:0]     i_req_addr,
  input  logic [p_WORD_LEN-1:0]     i_req_wdata,
  input  logic [2:0]                i_req_dest,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [p_WORD_LEN-1:0]     o_rsp_data,
  output logic [2:0]                o_rsp_dest,
  output logic                      o_mem_wr_en,
  output logic [p_MEM_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0]     o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0]     i_mem_rd_data,
  output logic [p_WORD_LEN-1:0]     o_led,
  output logic                      o_fault
);

  state_t                r_state;
  logic [p_WORD_LEN-1:0] r_rsp_data;
  logic [2:0]            r_rsp_dest;
  logic                  r_fault;

  logic                  w_is_ram;
  logic                  w_is_mmio;
  logic                  w_accept;
  logic                  w_mmio_wr;
  logic [p_WORD_LEN-1:0] w_mmio_rd_data;

  assign w_is_ram  = ((i_req_addr >> p_MEM_ADDR_LEN) == '0);
  assign w_is_mmio = !w_is_ram && (i_req_addr >= p_ADDR_LEN'(MMIO_BASE));
  assign w_accept  = (r_state == IDLE) && i_req_valid;
  assign w_mmio_wr = w_accept && i_req_we && w_is_mmio;

  mem_mmio #(
    .p_WORD_LEN (p_WORD_LEN),
    .p_ADDR_LEN (p_ADDR_LEN)
  ) u_mmio (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_mmio_wr),
    .i_addr    (i_req_addr),
    .i_wdata   (i_req_wdata),
    .o_rd_data (w_mmio_rd_data),
    .o_led     (o_led)
  );

  assign o_req_ready   = (r_state == IDLE);
  assign o_mem_wr_en   = w_accept && i_req_we && w_is_ram;
  assign o_mem_addr    = i_req_addr[p_MEM_ADDR_LEN-1:0];
  assign o_mem_wr_data = i_req_wdata;
  assign o_rsp_valid   = (r_state != IDLE);
  // RAM data is passed straight through for one cycle; only a stalled response is captured.
  assign o_rsp_data    = (r_state == LOAD_WAIT) ? i_mem_rd_data : r_rsp_data;
  assign o_rsp_dest    = r_rsp_dest;
  assign o_fault       = r_fault;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_rsp_data <= '0;
      r_rsp_dest <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_ram && !w_is_mmio) begin
              r_fault <= 1'b1;
            end
            if (!i_req_we) begin
              r_rsp_dest <= i_req_dest;
              if (w_is_ram) begin
                r_state <= LOAD_WAIT;
              end else begin
                r_rsp_data <= w_is_mmio ? w_mmio_rd_data : '0;
                r_state    <= RSP_HOLD;
              end
            end
          end
        end
        LOAD_WAIT: begin
          if (i_rsp_ready) begin
            r_state <= IDLE;
          end else begin
            r_rsp_data <= i_mem_rd_data;
            r_state    <= RSP_HOLD;
          end
        end
        RSP_HOLD: begin
          if (i_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with a behavioural data RAM.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  req_dest = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_dest;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] led;
  logic        fault;

  logic [15:0] ram [0:1023] = '{default: '0};
  logic [15:0] tb_cyc;
  logic [15:0] exp_cyc;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .p_WORD_LEN     (16),
    .p_ADDR_LEN     (16),
    .p_MEM_ADDR_LEN (10)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_we      (req_we),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .i_req_dest    (req_dest),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (rsp_data),
    .o_rsp_dest    (rsp_dest),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_data (mem_wr_data),
    .i_mem_rd_data (mem_rd_data),
    .o_led         (led),
    .o_fault       (fault)
  );

  // Synchronous RAM: one-cycle registered read of the presented address.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  // Reference cycle counter.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 16'd1;
  end

  task automatic drive(input logic v, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] t);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_dest = t;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (led !== 16'h0000) begin fails++; $display("FAIL reset_led: got %h expected 0000", led); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (rsp_data !== 16'h0000) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b0, 16'hFF01, 16'h0000, 3'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL cyc_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 16'd3) begin fails++; $display("FAIL cyc_after_reset: got %h expected 0003", rsp_data); end
    checks++; if (rsp_dest !== 3'd5) begin fails++; $display("FAIL cyc_dest: got %0d expected 5", rsp_dest); end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b1, 16'h0005, 16'h1234, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin fails++; $display("FAIL st_wr_en: got %b expected 1", mem_wr_en); end
    checks++; if (mem_addr !== 10'd5) begin fails++; $display("FAIL st_addr: got %h expected 005", mem_addr); end
    checks++; if (mem_wr_data !== 16'h1234) begin fails++; $display("FAIL st_wdata: got %h expected 1234", mem_wr_data); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL st_no_rsp: got %b expected 0", rsp_valid); end
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd3);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL ld_wr_en: got %b expected 0", mem_wr_en); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL ld_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h1234) begin fails++; $display("FAIL ld_data: got %h expected 1234", rsp_data); end
    checks++; if (rsp_dest !== 3'd3) begin fails++; $display("FAIL ld_dest: got %0d expected 3", rsp_dest); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL ld_busy: got %b expected 0", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL ld_done: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ld_ready_again: got %b expected 1", req_ready); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd6);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, rsp_valid); end
      checks++; if (rsp_data !== 16'h1234) begin fails++; $display("FAIL bp_data[%0d]: got %h expected 1234", i, rsp_data); end
      checks++; if (rsp_dest !== 3'd6) begin fails++; $display("FAIL bp_dest[%0d]: got %0d expected 6", i, rsp_dest); end
      checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_data !== 16'h1234) begin fails++; $display("FAIL bp_release_data: got %h expected 1234", rsp_data); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_done: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_again: got %b expected 1", req_ready); end
  endtask

  task automatic test_mmio();
    drive(1'b1, 1'b1, 16'hFF00, 16'hBEEF, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL led_wr_en: got %b expected 0", mem_wr_en); end
    @(negedge clk);
    checks++; if (led !== 16'hBEEF) begin fails++; $display("FAIL led_value: got %h expected beef", led); end
    drive(1'b1, 1'b1, 16'hFF01, 16'h0000, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hFF01, 16'h0000, 3'd4);
    exp_cyc = tb_cyc;
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_data !== exp_cyc) begin fails++; $display("FAIL cyc_not_written: got %h expected %h", rsp_data, exp_cyc); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hFF00, 16'h0000, 3'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_data !== 16'hBEEF) begin fails++; $display("FAIL led_read: got %h expected beef", rsp_data); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hFF05, 16'h0000, 3'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_data !== 16'h0000) begin fails++; $display("FAIL mmio_other_read: got %h expected 0000", rsp_data); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL mmio_no_fault: got %b expected 0", fault); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 16'h03FF, 16'h5A5A, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin fails++; $display("FAIL top_ram_wr_en: got %b expected 1", mem_wr_en); end
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0400, 16'hAAAA, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL oor_wr_en: got %b expected 0", mem_wr_en); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL oor_fault_set: got %b expected 1", fault); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h8000, 16'h0000, 3'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL oor_ld_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin fails++; $display("FAIL oor_ld_data: got %h expected 0000", rsp_data); end
    checks++; if (rsp_dest !== 3'd2) begin fails++; $display("FAIL oor_ld_dest: got %0d expected 2", rsp_dest); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h03FF, 16'h0000, 3'd1);
    checks++; if (rsp_data !== 16'h0000) begin fails++; $display("FAIL oor_no_alias: got %h expected 0000", rsp_data); end
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_data !== 16'h5A5A) begin fails++; $display("FAIL top_ram_read: got %h expected 5a5a", rsp_data); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL oor_fault_sticky: got %b expected 1", fault); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 16'h0010, 16'h1111, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin fails++; $display("FAIL b2b_st0: got %b expected 1", mem_wr_en); end
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0011, 16'h2222, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin fails++; $display("FAIL b2b_st1: got %b expected 1", mem_wr_en); end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 3'd1);
    @(negedge clk);
    checks++; if (rsp_data !== 16'h1111) begin fails++; $display("FAIL b2b_ld0_data: got %h expected 1111", rsp_data); end
    checks++; if (rsp_dest !== 3'd1) begin fails++; $display("FAIL b2b_ld0_dest: got %0d expected 1", rsp_dest); end
    drive(1'b1, 1'b0, 16'h0011, 16'h0000, 3'd2);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_data !== 16'h2222) begin fails++; $display("FAIL b2b_ld1_data: got %h expected 2222", rsp_data); end
    checks++; if (rsp_dest !== 3'd2) begin fails++; $display("FAIL b2b_ld1_dest: got %0d expected 2", rsp_dest); end
    @(negedge clk);
  endtask

  task automatic test_reset_midload();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd4);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_valid_before: got %b expected 1", rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_drop: got %b expected 0", rsp_valid); end
    checks++; if (led !== 16'h0000) begin fails++; $display("FAIL mid_led_reset: got %h expected 0000", led); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL mid_fault_reset: got %b expected 0", fault); end
    checks++; if (rsp_dest !== 3'd0) begin fails++; $display("FAIL mid_dest_reset: got %0d expected 0", rsp_dest); end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
    end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_mmio();
    test_out_of_range();
    test_back_to_back();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
